// File: rtl/fifo_stream_pkg.sv
// Shared widths, data type and sizing helper for the FIFO read streamer.
// Combinational definitions only; no latency or backpressure.
package fifo_stream_pkg;

  localparam int DEF_FIFO_WIDTH = 16;
  localparam int DEF_CNT_W      = 32;

  typedef logic [DEF_FIFO_WIDTH-1:0] data_t;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_rd_streamer_if.sv
// FIFO read port plus downstream valid/ready stream, as seen by the streamer (master).
// No latency; the stream side stalls on m_ready low.
interface fifo_rd_streamer_if
  import fifo_stream_pkg::*;
#(
  parameter int W = DEF_FIFO_WIDTH
);

  logic         fifo_rd_en;
  logic [W-1:0] fifo_dout;
  logic         fifo_empty;
  logic         fifo_underflow;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ready;

  modport master (
    output fifo_rd_en, m_data, m_valid,
    input  fifo_dout, fifo_empty, fifo_underflow, m_ready
  );

  modport slave (
    input  fifo_rd_en, m_data, m_valid,
    output fifo_dout, fifo_empty, fifo_underflow, m_ready
  );

endinterface

// File: rtl/stream_skid_buf.sv
// Circular buffer of DEPTH words; head is visible combinationally, 1-cycle write-to-visible.
// Pushes into a full buffer and pops from an empty one are ignored; clear wins over both.
module stream_skid_buf
  import fifo_stream_pkg::*;
#(
  parameter int W     = DEF_FIFO_WIDTH,
  parameter int DEPTH = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          push,
  input  logic [W-1:0]                  push_data,
  input  logic                          pop,
  output logic [W-1:0]                  head_data,
  output logic [occ_width(DEPTH)-1:0]   occ
);

  localparam int OW = occ_width(DEPTH);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop & (occ != '0) & ~clear;
  assign do_push = push & ~clear & ((occ != OW'(DEPTH)) | do_pop);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (do_push) tail <= nxt(tail);
      if (do_pop)  head <= nxt(head);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage carries no reset; head_data is masked while empty instead.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[tail] <= push_data;
  end

  assign head_data = (occ != '0) ? mem[head] : '0;

endmodule

// File: rtl/fifo_rd_streamer.sv
// Issues FIFO reads and re-times the 1-cycle read data into a valid/ready stream; rd_en->m_valid = 2 cycles.
// Reads are issued only while buffer space covers every in-flight word, so m_ready never reaches fifo_rd_en.
module fifo_rd_streamer
  import fifo_stream_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int BUF_DEPTH  = 3,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   flush,
  fifo_rd_streamer_if.master     bus,
  output logic [CNT_W-1:0]       words_out,
  output logic                   err_underflow,
  output logic                   busy
);

  localparam int OW = occ_width(BUF_DEPTH);

  logic [OW-1:0]         occ;
  logic [OW:0]           pending;
  logic                  inflight;
  logic                  discard;
  logic                  rd_en;
  logic                  push;
  logic                  pop;
  logic [FIFO_WIDTH-1:0] head_data;

  assign pending = {1'b0, occ} + {{OW{1'b0}}, inflight};
  assign rd_en   = ~rst & en & ~flush & ~bus.fifo_empty & (pending < (OW+1)'(BUF_DEPTH));

  // Flush drops both the returning word and any pop in the same cycle.
  assign push = inflight & ~discard & ~bus.fifo_underflow & ~flush;
  assign pop  = bus.m_valid & bus.m_ready & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight      <= 1'b0;
      discard       <= 1'b0;
      words_out     <= '0;
      err_underflow <= 1'b0;
    end else begin
      inflight <= rd_en;
      discard  <= flush & inflight;
      if (inflight && bus.fifo_underflow) err_underflow <= 1'b1;
      if (pop && (words_out != '1))       words_out <= words_out + 1'b1;
    end
  end

  stream_skid_buf #(
    .W     (FIFO_WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (push),
    .push_data (bus.fifo_dout),
    .pop       (pop),
    .head_data (head_data),
    .occ       (occ)
  );

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = (occ != '0);
  assign bus.m_data     = head_data;
  assign busy           = (occ != '0) | inflight;

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Bench for fifo_rd_streamer: FIFO source model, in-order scoreboard on the stream, directed and random steps.
// Stream words must equal the words taken from the FIFO, minus whatever a flush or reset threw away.
module tb_fifo_rd_streamer;
  import fifo_stream_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic flush;
  logic [DEF_CNT_W-1:0] words_out;
  logic err_underflow;
  logic busy;

  fifo_rd_streamer_if sif ();

  fifo_rd_streamer #(
    .FIFO_WIDTH (DEF_FIFO_WIDTH),
    .BUF_DEPTH  (3),
    .CNT_W      (DEF_CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .flush         (flush),
    .bus           (sif),
    .words_out     (words_out),
    .err_underflow (err_underflow),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  data_t fmem [64];
  int    fq_wr = 0;
  int    fq_rd = 0;
  data_t exp_q [$];
  int    vectors = 0;
  int    miscompares = 0;
  logic  inject_uf = 1'b0;
  logic  prev_stall = 1'b0;
  data_t prev_data;

  assign sif.fifo_empty = (fq_wr == fq_rd);

  // Source FIFO: registered read data; an injected read returns underflow instead of a word.
  always @(posedge clk) begin
    sif.fifo_underflow <= 1'b0;
    if (sif.fifo_rd_en === 1'b1) begin
      if (inject_uf) begin
        sif.fifo_underflow <= 1'b1;
        inject_uf = 1'b0;
      end else if (fq_rd != fq_wr) begin
        sif.fifo_dout <= fmem[fq_rd % 64];
        exp_q.push_back(fmem[fq_rd % 64]);
        fq_rd <= fq_rd + 1;
      end else begin
        sif.fifo_underflow <= 1'b1;
      end
    end
  end

  // Scoreboard: every accepted word must be the oldest word fetched and not since discarded.
  always @(negedge clk) begin
    if (prev_stall) begin
      vectors++;
      assert (sif.m_valid === 1'b1 && sif.m_data === prev_data) else begin
        miscompares++;
        $error("FAIL stall_hold observed v=%b d=%h required v=1 d=%h", sif.m_valid, sif.m_data, prev_data);
      end
    end
    prev_stall = 1'b0;
    if (rst === 1'b1) begin
      exp_q.delete();
    end else if (flush === 1'b1) begin
      exp_q.delete();
    end else if (sif.m_valid === 1'b1 && sif.m_ready === 1'b1) begin
      vectors++;
      assert (exp_q.size() != 0 && sif.m_data === exp_q[0]) else begin
        miscompares++;
        $error("FAIL stream_word observed %h required %h (pending %0d)", sif.m_data,
               (exp_q.size() != 0) ? exp_q[0] : '0, exp_q.size());
      end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end else if (sif.m_valid === 1'b1) begin
      prev_stall = 1'b1;
      prev_data  = sif.m_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sync();
    rst = 1'b1; en = 1'b0; flush = 1'b0; sif.m_ready = 1'b0; inject_uf = 1'b0;
    sync();
    rst = 1'b0;
  endtask

  task automatic load(input data_t first, input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      fmem[fq_wr % 64] = rnd ? data_t'($urandom) : first + data_t'(i);
      fq_wr++;
    end
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int k = 0;
    @(negedge clk);
    while (sif.m_valid !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, {31'd0, sif.m_valid}, 32'd1);
  endtask

  task automatic drain(input string tag, input int budget);
    int k = 0;
    sif.m_ready = 1'b1;
    en = 1'b1;
    @(negedge clk);
    while (!(fq_rd == fq_wr && exp_q.size() == 0 && busy === 1'b0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, exp_q.size() + (fq_wr - fq_rd), 32'd0);
    sync();
  endtask

  initial begin
    #200000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  initial begin
    int first_rd, last_rd, nrd, first_v, last_v, nv;
    rst = 1'b1; en = 1'b0; flush = 1'b0; sif.m_ready = 1'b0;

    // 1. Reset state, then an 8-word burst at full rate.
    do_reset();
    @(negedge clk);
    chk("rst_rd_en", {31'd0, sif.fifo_rd_en}, 32'd0);
    chk("rst_m_valid", {31'd0, sif.m_valid}, 32'd0);
    chk("rst_m_data", {16'd0, sif.m_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_words_out", words_out, 32'd0);
    chk("rst_err", {31'd0, err_underflow}, 32'd0);
    load(16'h0001, 8, 1'b0);
    sync();
    sif.m_ready = 1'b1; en = 1'b1;
    first_rd = -1; last_rd = -1; nrd = 0; first_v = -1; last_v = -1; nv = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (sif.fifo_rd_en === 1'b1) begin
        if (first_rd < 0) first_rd = c;
        last_rd = c; nrd++;
      end
      if (sif.m_valid === 1'b1) begin
        if (first_v < 0) first_v = c;
        last_v = c; nv++;
      end
    end
    chk("burst_reads", nrd, 32'd8);
    chk("burst_read_span", last_rd - first_rd, 32'd7);
    chk("burst_latency", first_v - first_rd, 32'd2);
    chk("burst_valids", nv, 32'd8);
    chk("burst_valid_span", last_v - first_v, 32'd7);
    chk("burst_words_out", words_out, 32'd8);
    chk("burst_busy_end", {31'd0, busy}, 32'd0);

    // 2. Consumer stalled: only BUF_DEPTH reads issue and the head word holds.
    do_reset();
    load(16'h0001, 8, 1'b0);
    sif.m_ready = 1'b0; en = 1'b1;
    nrd = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (sif.fifo_rd_en === 1'b1) nrd++;
    end
    chk("stall_reads", nrd, 32'd3);
    chk("stall_head", {16'd0, sif.m_data}, 32'h0001);
    sync();
    drain("stall_drain", 60);
    chk("stall_words_out", words_out, 32'd8);

    // 3. m_ready toggling, then random ready/enable over random data.
    do_reset();
    load('0, 24, 1'b1);
    en = 1'b1;
    for (int c = 0; c < 8; c++) begin
      sif.m_ready = c[0];
      sync();
    end
    for (int c = 0; c < 120; c++) begin
      sif.m_ready = 1'($urandom_range(0, 1));
      en = ($urandom_range(0, 3) != 0);
      sync();
    end
    drain("rand_drain", 100);
    chk("rand_words_out", words_out, 32'd24);

    // 4. Flush with occ=2 and one read in flight, m_ready high in the flush cycle.
    do_reset();
    load(16'h0001, 8, 1'b0);
    sif.m_ready = 1'b0; en = 1'b1;
    sync(); sync(); sync();
    flush = 1'b1; sif.m_ready = 1'b1;
    sync();
    flush = 1'b0; sif.m_ready = 1'b0;
    @(negedge clk);
    chk("flush_m_valid", {31'd0, sif.m_valid}, 32'd0);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_words_out", words_out, 32'd0);
    wait_valid("flush_refill", 10);
    chk("flush_next_word", {16'd0, sif.m_data}, 32'h0004);
    sync();
    drain("flush_drain", 60);
    chk("flush_words_total", words_out, 32'd5);

    // 5. Underflow returned on a read: sticky error, no spurious word.
    do_reset();
    load(16'h000A, 3, 1'b0);
    inject_uf = 1'b1;
    sif.m_ready = 1'b1; en = 1'b1;
    repeat (10) sync();
    chk("uf_err_set", {31'd0, err_underflow}, 32'd1);
    drain("uf_drain", 40);
    chk("uf_words_out", words_out, 32'd3);
    repeat (5) sync();
    chk("uf_err_sticky", {31'd0, err_underflow}, 32'd1);
    do_reset();
    @(negedge clk);
    chk("uf_err_cleared", {31'd0, err_underflow}, 32'd0);
    sync();

    // 6. Reset mid-burst with occ=2 and one read in flight.
    do_reset();
    load(16'h0011, 8, 1'b0);
    sif.m_ready = 1'b0; en = 1'b1;
    sync(); sync(); sync();
    rst = 1'b1; en = 1'b0;
    sync();
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_rd_en", {31'd0, sif.fifo_rd_en}, 32'd0);
    chk("mrst_m_valid", {31'd0, sif.m_valid}, 32'd0);
    chk("mrst_m_data", {16'd0, sif.m_data}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_words_out", words_out, 32'd0);
    sync();
    en = 1'b1;
    wait_valid("mrst_refill", 10);
    chk("mrst_next_word", {16'd0, sif.m_data}, 32'h0014);
    sync();
    drain("mrst_drain", 60);
    chk("mrst_words_total", words_out, 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_rd_streamer.md
Name: fifo_rd_streamer

Overview:
Downstream consumer of the synchronous FIFO (16-bit × 8). It issues FIFO reads and absorbs the FIFO's 1-cycle registered read latency in a small skid buffer. It presents the words as a valid/ready stream to the next stage. It also counts delivered words and flags FIFO protocol errors (underflow) for the bench and for status registers.

Parameters:
FIFO_WIDTH, 16, data word width; must match the FIFO.
BUF_DEPTH, 3, skid-buffer entries; minimum 2; 3 or more sustains 1 word/cycle.
CNT_W, 32, width of the delivered-word counter.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  synchronous, active-high reset.
en  in  1  enable read issue; when low, no new FIFO reads are issued.
flush  in  1  discard the buffer contents and any in-flight read; one-cycle pulse or level.
fifo_dout  in  FIFO_WIDTH  FIFO data_out, valid the cycle after rd_en is sampled.
fifo_empty  in  1  FIFO empty flag.
fifo_underflow  in  1  FIFO underflow flag, registered one cycle after the offending read.
fifo_rd_en  out  1  FIFO read request.
m_data  out  FIFO_WIDTH  stream data.
m_valid  out  1  stream valid.
m_ready  in  1  stream ready from the consumer.
words_out  out  CNT_W  count of words accepted downstream; saturates at all-ones.
err_underflow  out  1  sticky: the FIFO signalled underflow on a read issued by this block.
busy  out  1  high when buffer occupancy != 0 or a read is in flight.

Behaviour:
- Reset (rst sampled high): occ=0, inflight=0, discard=0, buffer pointers=0, words_out=0, err_underflow=0. Outputs fifo_rd_en=0, m_valid=0, m_data=0, busy=0. Reset wins over every other input.
- Issue rule, combinational from registered state only (no path from m_ready):
  - fifo_rd_en = en & ~flush & ~fifo_empty & ((occ + inflight) < BUF_DEPTH).
- inflight <= fifo_rd_en. Return cycle = the cycle after fifo_rd_en is high. In the return cycle fifo_dout holds the read word.
- Push in the return cycle when inflight & ~discard & ~fifo_underflow & ~flush. The word is written at the buffer tail.
- If inflight & fifo_underflow: no push, and err_underflow <= 1. It stays set until rst.
- Pop occurs when m_valid & m_ready. m_valid = (occ != 0). m_data = buffer head; m_data = 0 when occ=0.
- m_data and m_valid must stay stable while m_valid & ~m_ready.
- Ordering is strictly FIFO order.
- Simultaneous push and pop: occ unchanged. Head and tail both advance, wrapping modulo BUF_DEPTH.
- Latency: rd_en in cycle t → data captured at the end of t+1 → m_valid in t+2, provided the buffer was empty.
- Throughput: with BUF_DEPTH ≥ 3, m_ready held high and the FIFO non-empty, one word is delivered per cycle.
- Flush (sampled high):
  - occ <= 0 and pointers <= 0; fifo_rd_en is forced low.
  - discard <= inflight, so data arriving in the next cycle is dropped. discard then clears.
  - Flush has priority over push and pop. words_out is not changed by flush.
- en deasserted mid-burst: no new reads. An in-flight read still completes and buffered words still drain.
- words_out increments on each pop. It holds at 2^CNT_W−1 once it reaches that value.
- busy = (occ != 0) | inflight.
- Arithmetic: occ is $clog2(BUF_DEPTH+1) bits wide; the occ + inflight sum is evaluated at that width plus 1.

Decomposition:
- Package fifo_stream_pkg holds:
  - FIFO_WIDTH default (16) and CNT_W default (32);
  - typedef data_t as logic [FIFO_WIDTH-1:0];
  - function occ_width(depth) returning $clog2(depth+1).
- One sub-module: stream_skid_buf.
  - Contains the BUF_DEPTH circular buffer, head/tail/occ, and push/pop/clear ports.
  - Issue, inflight/discard, error and counter logic stay in the top level.

Test Plan:
- FIFO preloaded with 0x0001..0x0008, en=1, m_ready=1 → rd_en high for 8 consecutive cycles; m_valid high 2 cycles after the first read; m_data = 0x0001..0x0008 on consecutive cycles; words_out=8; busy falls after the last pop.
- Same 8 words, m_ready=0 → fifo_rd_en stops after 3 reads (occ=3); m_data holds 0x0001 stable. Then m_ready=1 → remaining words drain in order; words_out=8.
- m_ready toggled 1,0,1,0 with the FIFO non-empty → no word lost or duplicated; m_data is unchanged across each stalled cycle.
- flush pulsed in the cycle after a read, with occ=2 → m_valid=0 the next cycle; the in-flight word is discarded; the next read after flush returns the following FIFO word; words_out is unchanged.
- Model drives fifo_underflow=1 in a return cycle → no push; err_underflow=1 and stays 1 until rst; m_valid unaffected.
- rst asserted mid-burst, with occ=2 and inflight=1 → next cycle all outputs are 0, words_out=0; the in-flight data is ignored.
